// File: rtl/rv32_instr_decoder.sv
// Registered RV32I/RV32M field decoder: opcode, register indices, {funct7,funct3} and immediate.
// Define RV32M_DECODE_EN to accept the funct7=0000001 multiply/divide R-type encodings.
module rv32_instr_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [6:0]  op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [9:0]  func,
    output logic [31:0] imm,
    output logic        illegal
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;

    logic [6:0]  op_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [9:0]  func_d;
    logic [31:0] imm_d;
    logic        illegal_d;

    assign opcode = instr[6:0];
    assign f7     = instr[31:25];
    assign f3     = instr[14:12];

    always_comb begin
        op_d      = opcode;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        func_d    = '0;
        imm_d     = '0;
        illegal_d = 1'b0;

        case (opcode)
            OpReg: begin
                rs1_d  = instr[19:15];
                rs2_d  = instr[24:20];
                rd_d   = instr[11:7];
                func_d = {f7, f3};
                case (f7)
                    F7Zero: ;
                    F7Alt: illegal_d = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef RV32M_DECODE_EN
                    F7Mul: ;
`endif
                    default: illegal_d = 1'b1;
                endcase
            end
            OpImm: begin
                rs1_d = instr[19:15];
                rd_d  = instr[11:7];
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift amount is unsigned; funct7 selects logical vs arithmetic.
                    func_d    = {f7, f3};
                    imm_d     = {27'b0, instr[24:20]};
                    illegal_d = (f3 == 3'b001) ? (f7 != F7Zero)
                                               : !((f7 == F7Zero) || (f7 == F7Alt));
                end else begin
                    func_d = {7'b0, f3};
                    imm_d  = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OpLoad, OpJalr: begin
                rs1_d  = instr[19:15];
                rd_d   = instr[11:7];
                func_d = {7'b0, f3};
                imm_d  = {{20{instr[31]}}, instr[31:20]};
                if (opcode == OpLoad) begin
                    illegal_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                end else begin
                    illegal_d = (f3 != 3'b000);
                end
            end
            OpStore: begin
                rs1_d     = instr[19:15];
                rs2_d     = instr[24:20];
                func_d    = {7'b0, f3};
                imm_d     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                illegal_d = (f3 > 3'b010);
            end
            OpBranch: begin
                rs1_d     = instr[19:15];
                rs2_d     = instr[24:20];
                func_d    = {7'b0, f3};
                imm_d     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                illegal_d = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OpLui, OpAuipc: begin
                rd_d  = instr[11:7];
                imm_d = {instr[31:12], 12'b0};
            end
            OpJal: begin
                rd_d  = instr[11:7];
                imm_d = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: illegal_d = 1'b1;
        endcase

        // Illegal decodes keep only the opcode so downstream never sees stale fields.
        if (illegal_d) begin
            rs1_d  = '0;
            rs2_d  = '0;
            rd_d   = '0;
            func_d = '0;
            imm_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            func    <= '0;
            imm     <= '0;
            illegal <= 1'b0;
        end else begin
            op      <= op_d;
            rs1     <= rs1_d;
            rs2     <= rs2_d;
            rd      <= rd_d;
            func    <= func_d;
            imm     <= imm_d;
            illegal <= illegal_d;
        end
    end

endmodule

// File: tb/tb_rv32_instr_decoder.sv
// Scoreboard bench for rv32_instr_decoder: directed ISA examples, reset mid-stream, random words.
// Honours RV32M_DECODE_EN the same way the design does.
module tb_rv32_instr_decoder;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  func;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  func;
    logic [31:0] imm;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    dec_t        exp_q[$];
    logic [31:0] ins_q[$];

    rv32_instr_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .instr   (instr),
        .op      (op),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .func    (func),
        .imm     (imm),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

`ifdef RV32M_DECODE_EN
    localparam bit MEn = 1'b1;
`else
    localparam bit MEn = 1'b0;
`endif

    // Reference decode built from field arithmetic on signed integers.
    function automatic dec_t model(input logic [31:0] i);
        dec_t d;
        int   f7, f3, v;
        bit   ok;
        d  = '0;
        f7 = int'(i[31:25]);
        f3 = int'(i[14:12]);
        ok = 1'b1;
        d.op = i[6:0];
        case (i[6:0])
            7'h33: begin
                d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
                d.func = {i[31:25], i[14:12]};
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (MEn && f7 == 1);
            end
            7'h13: begin
                d.rs1 = i[19:15]; d.rd = i[11:7];
                if (f3 == 1 || f3 == 5) begin
                    d.func = {i[31:25], i[14:12]};
                    d.imm  = 32'((i >> 20) % 32);
                    ok = (f7 == 0) || (f3 == 5 && f7 == 32);
                end else begin
                    d.func = 10'(f3);
                    d.imm  = 32'($signed(i) >>> 20);
                end
            end
            7'h03, 7'h67: begin
                d.rs1 = i[19:15]; d.rd = i[11:7];
                d.func = 10'(f3);
                d.imm  = 32'($signed(i) >>> 20);
                ok = (i[6:0] == 7'h03) ? !(f3 == 3 || f3 == 6 || f3 == 7) : (f3 == 0);
            end
            7'h23: begin
                d.rs1 = i[19:15]; d.rs2 = i[24:20];
                d.func = 10'(f3);
                v = int'($signed(i) >>> 25) * 32 + int'(i[11:7]);
                d.imm = 32'(v);
                ok = (f3 <= 2);
            end
            7'h63: begin
                d.rs1 = i[19:15]; d.rs2 = i[24:20];
                d.func = 10'(f3);
                v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                    + int'(i[11:8]) * 2;
                d.imm = 32'(v);
                ok = (f3 != 2) && (f3 != 3);
            end
            7'h37, 7'h17: begin
                d.rd = i[11:7];
                d.imm = i & 32'hFFFF_F000;
            end
            7'h6F: begin
                d.rd = i[11:7];
                v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                    + int'(i[30:21]) * 2;
                d.imm = 32'(v);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d = '0;
            d.op = i[6:0];
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    task automatic send(input logic [31:0] i, input logic r);
        @(negedge clk);
        instr = i;
        rst   = r;
        exp_q.push_back(r ? dec_t'('0) : model(i));
        ins_q.push_back(i);
    endtask

    // Monitor: every output cycle with a pending expectation is compared.
    initial begin
        dec_t        e, a;
        logic [31:0] wi;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                wi = ins_q.pop_front();
                a  = '{op, rs1, rs2, rd, func, imm, illegal};
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL decode instr=%08h actual op=%h rs1=%0d rs2=%0d rd=%0d func=%b imm=%08h ill=%b required op=%h rs1=%0d rs2=%0d rd=%0d func=%b imm=%08h ill=%b",
                             wi, a.op, a.rs1, a.rs2, a.rd, a.func, a.imm, a.illegal,
                             e.op, e.rs1, e.rs2, e.rd, e.func, e.imm, e.illegal);
                end
            end
        end
    end

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) r[6:0] = ops[k];
        case ($urandom_range(0, 4))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    logic [31:0] directed [10] = '{32'h002081B3, 32'hFFF00093, 32'h4030D093, 32'h0020A423,
                                   32'hFE208EE3, 32'h123452B7, 32'h008000EF, 32'h022081B3,
                                   32'h00000000, 32'h40209093};

    initial begin
        send(32'h002081B3, 1'b1);
        send(32'h002081B3, 1'b1);
        for (int k = 0; k < 10; k++) send(directed[k], 1'b0);
        // Reset asserted mid-stream discards the in-flight decode.
        send(32'hFFF00093, 1'b0);
        send(32'h123452B7, 1'b1);
        send(32'h0020A423, 1'b0);
        send(32'hFE208EE3, 1'b0);
        for (int k = 0; k < 600; k++) begin
            send(rand_instr(), ($urandom_range(0, 49) == 0));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
